approx_mul_sched: RTL and testbench
===================================

# approx_mul_sched

Two-requester scheduler and sequencer for the shared 8x8 approximate-multiplier first stage (ATC8/ATC4/iCAC compression to P7/Q7 with error vectors V1/V2). It arbitrates operand requests round-robin and generates the partial-product matrix. It holds the matrix stable while the combinational compressor tree settles, captures the stage outputs, and finishes the product. Finishing is either approximate (P7+Q7) or error-recovered (P7+Q7+correction). It sits between the SAP3 execute unit and the multiplier datapath, which is instantiated beside it and wired through the s1_* ports.

## Interface
Parameters:
- SETTLE_CYCLES, 2: cycles the pp matrix is held before the stage outputs are captured; legal range 1..15.
- V1_SHIFT, 1: left shift applied to V1 in the correction term.
- V2_SHIFT, 3: left shift applied to V2 in the correction term.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester operand valid.
- req_ready  out  2  per-requester accept; at most one bit high.
- req_a0, req_b0  in  8 each  requester 0 operands.
- req_a1, req_b1  in  8 each  requester 1 operands.
- req_approx  in  2  per-requester mode: 1 = approximate, 0 = error-recovered.
- pp  out  [7:0][7:0]  partial products to the stage: pp[i][j] = a[j] & b[i].
- s1_p7, s1_q7  in  15 each  stage sum and carry rows.
- s1_v1  in  13  stage error vector 1.
- s1_v2  in  11  stage error vector 2.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_id  out  1  index of the requester that owns the result.
- rsp_approx  out  1  mode used for the result.
- rsp_product  out  16  product.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SETTLE, SUM, FIX, RESP.
- IDLE
  - Grant follows round-robin pointer ptr; ptr = 0 after reset.
  - If req_valid[ptr] is high, grant ptr. Otherwise, if the other bit is high, grant the other requester.
  - req_ready[g] = 1 only for the granted g, combinationally, in IDLE only.
  - On req_valid[g] & req_ready[g]: latch a, b, approx and id = g; set ptr = ~g; set the settle counter to 0; go to SETTLE.
- SETTLE
  - pp is driven from the latched operands. pp = 0 in every other state.
  - The counter increments each cycle.
  - On the edge where counter == SETTLE_CYCLES-1: register s1_p7, s1_q7, s1_v1 and s1_v2, then go to SUM.
- SUM
  - sum = zext16(P7) + zext16(Q7), mod 2^16, registered.
  - Next state is RESP if approx = 1, otherwise FIX.
- FIX
  - sum = sum + (zext16(V1) << V1_SHIFT) + (zext16(V2) << V2_SHIFT), mod 2^16; bits shifted past bit 15 are dropped.
  - Next state is RESP.
- RESP
  - rsp_valid = 1, with rsp_product, rsp_id and rsp_approx stable.
  - Hold until rsp_ready, then go to IDLE on that edge.
- Reset values
  - All outputs 0: rsp_valid, rsp_id, rsp_approx, rsp_product, pp, req_ready, busy.
  - State IDLE, ptr 0.
- Reset in any state aborts the operation. Nothing is emitted, and the pending result is discarded.
- Requests arriving while busy are not accepted; req_ready stays low. Requesters hold req_valid until accepted.

## Timing
- Accept on edge k. rsp_valid goes high after edge k+SETTLE_CYCLES+1 in approximate mode, or after edge k+SETTLE_CYCLES+2 in recovered mode. With defaults, that is 3 or 4 cycles.
- pp changes only on the accept edge and returns to 0 on the edge leaving SETTLE.
- After the response handshake, one IDLE cycle occurs before the next accept. Minimum issue interval is SETTLE_CYCLES+3 cycles (approximate) or SETTLE_CYCLES+4 (recovered).
- If rsp_ready is already high when rsp_valid rises, RESP lasts one cycle.
- Simultaneous req_valid = 2'b11 after reset: grants go 0, 1, 0, 1 …
- A single persistent requester is re-granted each time, whatever ptr is.

## Test plan
- Partial products: requester 0, a=8'hA5, b=8'h03, SETTLE_CYCLES=2. During SETTLE, pp[0]=pp[1]=8'hA5 and pp[2..7]=0. In IDLE, pp=0.
- Approximate result: stub returns P7=15'h0100, Q7=15'h0023, V1=13'h0004, V2=11'h0001, with approx=1. Expect rsp_product=16'h0123, rsp_id=0, rsp_approx=1, and rsp_valid exactly 3 cycles after accept.
- Recovered result: same stub with approx=0. Expect rsp_product=16'h0133 (0x0123 + 0x8 + 0x8), 4 cycles after accept.
- Wrap-around: stub P7=Q7=15'h7FFF, V1=13'h1FFF, V2=11'h7FF, approx=0. Expect rsp_product=16'h7FF4.
- Arbitration and backpressure: both req_valid held high with rsp_ready low for 5 cycles during each RESP. Expect:
  - grant order 0, 1, 0;
  - rsp_product stable and req_ready=0 throughout each stall.
- Reset mid-operation: assert rst for one cycle during SUM. Expect:
  - the next cycle shows IDLE, busy=0, rsp_valid=0 and pp=0;
  - no response is ever emitted for the aborted request;
  - the next simultaneous request is granted to requester 0.

Source files
------------

// File: rtl/approx_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : approx_mul_sched
// Description : Two-requester round-robin scheduler and sequencer for the
//               shared 8x8 approximate-multiplier first stage. It accepts one
//               operand pair and drives the partial-product matrix. It holds
//               that matrix while the external compressor tree settles, then
//               captures P7/Q7/V1/V2. It finishes the product as approximate
//               (P7+Q7) or error-recovered (P7+Q7+shifted V1/V2).
// Ports       : clk, rst                  clock, synchronous active-high reset
//               req_valid/req_ready [1:0] per-requester handshake
//               req_a0/b0, req_a1/b1      operands of requester 0 / 1
//               req_approx [1:0]          1 = approximate, 0 = recovered
//               pp [7:0][7:0]             partial products, pp[i][j]=a[j]&b[i]
//               s1_p7/q7/v1/v2            first-stage outputs from datapath
//               rsp_valid/rsp_ready       result handshake
//               rsp_id, rsp_approx        owner and mode of the result
//               rsp_product [15:0]        product
//               busy                      high outside IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module approx_mul_sched #(
  parameter int SETTLE_CYCLES = 2,
  parameter int V1_SHIFT      = 1,
  parameter int V2_SHIFT      = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [7:0]      req_a0,
  input  logic [7:0]      req_b0,
  input  logic [7:0]      req_a1,
  input  logic [7:0]      req_b1,
  input  logic [1:0]      req_approx,
  output logic [7:0][7:0] pp,
  input  logic [14:0]     s1_p7,
  input  logic [14:0]     s1_q7,
  input  logic [12:0]     s1_v1,
  input  logic [10:0]     s1_v2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic            rsp_approx,
  output logic [15:0]     rsp_product,
  output logic            busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_SUM    = 3'd2,
    S_FIX    = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic [3:0] C_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic        ptr_q;
  logic [7:0]  a_q, b_q;
  logic        approx_q;
  logic        id_q;
  logic [3:0]  cnt_q;
  logic [14:0] p7_q, q7_q;
  logic [12:0] v1_q;
  logic [10:0] v2_q;
  logic [15:0] sum_q;

  logic        w_grant_any;
  logic        w_grant_id;
  logic        w_accept;
  logic        w_capture;
  logic [15:0] w_v1_term;
  logic [15:0] w_v2_term;

  // The pointer holder wins when valid; otherwise the other requester may
  // take the slot, so a lone requester is never starved by the pointer.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_id  = ptr_q;
    if (req_valid[ptr_q]) begin
      w_grant_any = 1'b1;
      w_grant_id  = ptr_q;
    end else if (req_valid[~ptr_q]) begin
      w_grant_any = 1'b1;
      w_grant_id  = ~ptr_q;
    end
  end

  assign w_accept  = (state_q == S_IDLE) && w_grant_any;
  assign w_capture = (state_q == S_SETTLE) && (cnt_q == C_SETTLE_LAST);

  // Shifting in a 16-bit context drops anything pushed past bit 15.
  assign w_v1_term = 16'(v1_q) << V1_SHIFT;
  assign w_v2_term = 16'(v2_q) << V2_SHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready   = 2'b00;
    rsp_valid   = 1'b0;
    rsp_id      = 1'b0;
    rsp_approx  = 1'b0;
    rsp_product = 16'h0000;
    busy        = (state_q != S_IDLE);
    for (int i = 0; i < 8; i++) begin
      pp[i] = 8'h00;
    end

    case (state_q)
      S_IDLE: begin
        if (w_grant_any) begin
          req_ready = w_grant_id ? 2'b10 : 2'b01;
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Row i of the matrix is operand a gated by bit i of operand b.
        for (int i = 0; i < 8; i++) begin
          pp[i] = b_q[i] ? a_q : 8'h00;
        end
        if (w_capture) begin
          state_d = S_SUM;
        end
      end
      S_SUM: begin
        state_d = approx_q ? S_RESP : S_FIX;
      end
      S_FIX: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid   = 1'b1;
        rsp_id      = id_q;
        rsp_approx  = approx_q;
        rsp_product = sum_q;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= 1'b0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      approx_q <= 1'b0;
      id_q     <= 1'b0;
      cnt_q    <= 4'd0;
      p7_q     <= 15'h0000;
      q7_q     <= 15'h0000;
      v1_q     <= 13'h0000;
      v2_q     <= 11'h000;
      sum_q    <= 16'h0000;
    end else begin
      if (w_accept) begin
        a_q      <= w_grant_id ? req_a1 : req_a0;
        b_q      <= w_grant_id ? req_b1 : req_b0;
        approx_q <= req_approx[w_grant_id];
        id_q     <= w_grant_id;
        ptr_q    <= ~w_grant_id;
        cnt_q    <= 4'd0;
      end
      if (state_q == S_SETTLE) begin
        cnt_q <= cnt_q + 4'd1;
      end
      if (w_capture) begin
        p7_q <= s1_p7;
        q7_q <= s1_q7;
        v1_q <= s1_v1;
        v2_q <= s1_v2;
      end
      if (state_q == S_SUM) begin
        sum_q <= 16'(p7_q) + 16'(q7_q);
      end
      if (state_q == S_FIX) begin
        sum_q <= sum_q + w_v1_term + w_v2_term;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_approx_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_approx_mul_sched
// Description : Self-checking bench for approx_mul_sched. Directed cases
//               followed by randomized transactions, compared against a
//               behavioural model of grant order, matrix, latency and product.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_mul_sched;

  localparam int SC = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [7:0]      req_a0, req_b0, req_a1, req_b1;
  logic [1:0]      req_approx;
  logic [7:0][7:0] pp;
  logic [14:0]     s1_p7, s1_q7;
  logic [12:0]     s1_v1;
  logic [10:0]     s1_v2;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic            rsp_approx;
  logic [15:0]     rsp_product;
  logic            busy;

  int vectors     = 0;
  int miscompares = 0;
  int ptr_m       = 0;

  always #5 clk = ~clk;

  approx_mul_sched #(
    .SETTLE_CYCLES(SC),
    .V1_SHIFT     (1),
    .V2_SHIFT     (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .req_approx (req_approx),
    .pp         (pp),
    .s1_p7      (s1_p7),
    .s1_q7      (s1_q7),
    .s1_v1      (s1_v1),
    .s1_v2      (s1_v2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_approx (rsp_approx),
    .rsp_product(rsp_product),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit j of row i is a[j] AND b[i]: each row is a copy of a or zero.
  function automatic logic [63:0] pp_model(input logic [7:0] a, input logic [7:0] b);
    logic [63:0] r;
    r = 64'h0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        r[i*8 + j] = a[j] & b[i];
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] prod_model(input logic [14:0] p7, input logic [14:0] q7,
                                             input logic [12:0] v1, input logic [10:0] v2,
                                             input logic apx);
    longint s;
    s = longint'(p7) + longint'(q7);
    if (!apx) s = s + longint'(v1) * 2 + longint'(v2) * 8;
    return 16'(s % 65536);
  endfunction

  task automatic txn(input string tag, input logic [1:0] vld,
                     input logic [7:0] a0, input logic [7:0] b0,
                     input logic [7:0] a1, input logic [7:0] b1,
                     input logic [1:0] apx, input int stall,
                     input logic [14:0] p7, input logic [14:0] q7,
                     input logic [12:0] v1, input logic [10:0] v2);
    int          g;
    int          lat;
    logic [7:0]  ea, eb;
    logic        eapx;
    logic [15:0] ep;
    req_valid  = vld;
    req_a0     = a0;
    req_b0     = b0;
    req_a1     = a1;
    req_b1     = b1;
    req_approx = apx;
    s1_p7      = p7;
    s1_q7      = q7;
    s1_v1      = v1;
    s1_v2      = v2;
    rsp_ready  = 1'b0;
    #1;
    g    = vld[ptr_m] ? ptr_m : 1 - ptr_m;
    ea   = (g == 1) ? a1 : a0;
    eb   = (g == 1) ? b1 : b0;
    eapx = apx[g];
    ep   = prod_model(p7, q7, v1, v2, eapx);
    check({tag, " grant"}, 64'(req_ready), (g == 1) ? 64'h2 : 64'h1);
    tick();
    ptr_m = 1 - g;
    lat   = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      check({tag, " pp"}, pp, (lat < SC) ? pp_model(ea, eb) : 64'h0);
      check({tag, " ready_busy"}, {62'h0, req_ready}, 64'h0);
      check({tag, " busy"}, 64'(busy), 64'h1);
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(SC + 1 + (eapx ? 0 : 1)));
    check({tag, " product"}, 64'(rsp_product), 64'(ep));
    check({tag, " id"}, 64'(rsp_id), 64'(g));
    check({tag, " mode"}, 64'(rsp_approx), 64'(eapx));
    for (int s = 0; s < stall; s++) begin
      tick();
      check({tag, " stall_valid"}, 64'(rsp_valid), 64'h1);
      check({tag, " stall_product"}, 64'(rsp_product), 64'(ep));
      check({tag, " stall_ready"}, 64'(req_ready), 64'h0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 2'b00;
    #1;
    check({tag, " post_valid"}, 64'(rsp_valid), 64'h0);
    check({tag, " post_busy"}, 64'(busy), 64'h0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b00;
    req_a0     = 8'h00;
    req_b0     = 8'h00;
    req_a1     = 8'h00;
    req_b1     = 8'h00;
    req_approx = 2'b00;
    s1_p7      = 15'h0;
    s1_q7      = 15'h0;
    s1_v1      = 13'h0;
    s1_v2      = 11'h0;
    rsp_ready  = 1'b0;
    tick();
    tick();
    check("reset rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset rsp_id", 64'(rsp_id), 64'h0);
    check("reset rsp_approx", 64'(rsp_approx), 64'h0);
    check("reset rsp_product", 64'(rsp_product), 64'h0);
    check("reset pp", pp, 64'h0);
    check("reset req_ready", 64'(req_ready), 64'h0);
    check("reset busy", 64'(busy), 64'h0);
    rst = 1'b0;
    tick();

    // Directed: matrix, approximate, recovered, wrap-around
    txn("pp_approx", 2'b01, 8'hA5, 8'h03, 8'h00, 8'h00, 2'b11, 0,
        15'h0100, 15'h0023, 13'h0004, 11'h001);
    txn("recovered", 2'b01, 8'hA5, 8'h03, 8'h00, 8'h00, 2'b00, 0,
        15'h0100, 15'h0023, 13'h0004, 11'h001);
    txn("wrap", 2'b10, 8'h00, 8'h00, 8'hFF, 8'h81, 2'b00, 1,
        15'h7FFF, 15'h7FFF, 13'h1FFF, 11'h7FF);

    // Both requesters held: pointer alternates; each RESP stalled 5 cycles
    for (int k = 0; k < 3; k++) begin
      txn("arb", 2'b11, 8'h12, 8'h34, 8'h56, 8'h78, 2'b10, 5,
          15'h1234, 15'h0F0F, 13'h0ABC, 11'h155);
    end

    // Randomized transactions
    for (int k = 0; k < 10; k++) begin
      txn("rand", 2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom),
          8'($urandom), 8'($urandom), 2'($urandom), int'($urandom_range(0, 3)),
          15'($urandom), 15'($urandom), 13'($urandom), 11'($urandom));
    end

    // Reset during SUM aborts the operation
    req_valid  = 2'b01;
    req_a0     = 8'h3C;
    req_b0     = 8'h11;
    req_approx = 2'b00;
    #1;
    check("abort grant", 64'(req_ready), 64'h1);
    tick();
    ptr_m     = 1;
    req_valid = 2'b00;
    tick();
    tick();
    check("abort busy_before", 64'(busy), 64'h1);
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    ptr_m = 0;
    #1;
    check("abort busy", 64'(busy), 64'h0);
    check("abort rsp_valid", 64'(rsp_valid), 64'h0);
    check("abort pp", pp, 64'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("abort no_rsp", 64'(rsp_valid), 64'h0);
    end
    txn("post_abort", 2'b11, 8'h9A, 8'hC3, 8'h11, 8'h22, 2'b01, 0,
        15'h0456, 15'h0789, 13'h0101, 11'h011);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
